// File: rtl/adder_seq_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder.
package adder_seq_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multicycle_adder_seq_slice.sv
// Combinational 4-bit ripple-carry adder built from full-adder cells.
module adder_slice_4bit
    import adder_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               carry_in,
    output logic [SLICE_W-1:0] sum,
    output logic               carry_out
);

    always_comb begin
        logic c;
        sum = '0;
        c   = carry_in;
        for (int unsigned i = 0; i < SLICE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out = c;
    end

endmodule

// File: rtl/multicycle_adder_seq.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit slice, LSB first, valid/ready on both sides.
// Optional subtract mode (op_sub port) enabled by defining ADDER_SEQ_SUB_EN.
module multicycle_adder_seq
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef ADDER_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("multicycle_adder_seq: WIDTH must be a multiple of 4 and >= 4");
    end

    state_e                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             carry_q, carry_d;
    logic                             cout_q, cout_d;
    logic                             ovalid_q, ovalid_d;
    logic [NSLICE-1:0][SLICE_W-1:0]   sum_q, sum_d;
    logic [NSLICE-1:0][SLICE_W-1:0]   a_q, b_q;
    logic [WIDTH-1:0]                 b_eff;
    logic                             cin_eff;
    logic                             load;
    logic [SLICE_W-1:0]               slice_sum;
    logic                             slice_cout;

    // Subtraction folds into addition: invert b at capture and force the carry-in.
`ifdef ADDER_SEQ_SUB_EN
    assign b_eff   = op_sub ? ~b : b;
    assign cin_eff = op_sub | carry_in;
`else
    assign b_eff   = b;
    assign cin_eff = carry_in;
`endif

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = ovalid_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

    adder_slice_4bit u_slice (
        .a         (a_q[idx_q]),
        .b         (b_q[idx_q]),
        .carry_in  (carry_q),
        .sum       (slice_sum),
        .carry_out (slice_cout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovalid_d = ovalid_q;
        sum_d    = sum_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    carry_d = cin_eff;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = slice_sum;
                carry_d      = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d   = slice_cout;
                    ovalid_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (ovalid_q && out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovalid_q <= 1'b0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovalid_q <= ovalid_d;
            sum_q    <= sum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= a;
            b_q <= b_eff;
        end
    end

endmodule
